// File: rtl/rv32i_types.sv
// Shared definitions for the cache-line to burst adapter: FSM state encoding and beats per line.
package rv32i_types;

  localparam int LINE_BEATS = 4;

  typedef enum logic [2:0] {
    IDLE,
    RD_BURST,
    RD_DONE,
    WR_BURST,
    WR_DONE
  } line_adapter_state_t;

endpackage

// File: rtl/line_beat_buffer.sv
// Line gather/scatter buffer plus beat counter: full-line load, per-beat store/step, wraps after last beat.
// beat_dat_o is the slice under the counter; fill_o is the buffer with that slice replaced by beat_dat_i.
module line_beat_buffer
  import rv32i_types::*;
#(
  parameter int beat_width = 64
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               load_i,
  input  logic [LINE_BEATS*beat_width-1:0]   load_dat_i,
  input  logic                               step_i,
  input  logic                               store_i,
  input  logic [beat_width-1:0]              beat_dat_i,
  output logic [beat_width-1:0]              beat_dat_o,
  output logic [LINE_BEATS*beat_width-1:0]   fill_o,
  output logic                               last_o
);

  localparam int line_w = LINE_BEATS * beat_width;
  localparam int cnt_w  = $clog2(LINE_BEATS);

  logic [line_w-1:0] buf_q;
  logic [cnt_w-1:0]  beat_q;

  assign last_o     = (beat_q == cnt_w'(LINE_BEATS - 1));
  assign beat_dat_o = buf_q[int'(beat_q)*beat_width +: beat_width];

  always_comb begin
    fill_o = buf_q;
    fill_o[int'(beat_q)*beat_width +: beat_width] = beat_dat_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q  <= '0;
      beat_q <= '0;
    end else if (load_i) begin
      buf_q  <= load_dat_i;
      beat_q <= '0;
    end else if (step_i) begin
      if (store_i) buf_q <= fill_o;
      beat_q <= last_o ? '0 : beat_q + 1'b1;
    end
  end

endmodule

// File: rtl/line_burst_adapter.sv
// Converts 256-bit line reads/writes into 4x64-bit bursts; line_resp 5 cycles after request with no stalls.
// LINE_ADAPTER_POSTED_WRITE_EN acknowledges writes in the first burst cycle instead of after the last beat.
module line_burst_adapter
  import rv32i_types::*;
#(
  parameter int width      = 256,
  parameter int beat_width = 64,
  parameter int s_offset   = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  line_read,
  input  logic                  line_write,
  input  logic [31:0]           line_address,
  input  logic [width-1:0]      line_wdata,
  output logic [width-1:0]      line_rdata,
  output logic                  line_resp,
  output logic                  burst_read,
  output logic                  burst_write,
  output logic [31:0]           burst_address,
  output logic [beat_width-1:0] burst_wdata,
  input  logic [beat_width-1:0] burst_rdata,
  input  logic                  burst_resp
);

  localparam logic [31:0] addr_mask = ~((32'd1 << s_offset) - 32'd1);

  line_adapter_state_t state_q;
  logic                burst_read_q;
  logic                burst_write_q;
  logic                line_resp_q;
  logic [31:0]         burst_address_q;
  logic [width-1:0]    line_rdata_q;
  logic [width-1:0]    fill_d;
  logic                last_beat;
  logic                load;
  logic                step;
  logic                store;

  assign load  = (state_q == IDLE) && line_write;
  assign step  = burst_resp && ((state_q == RD_BURST) || (state_q == WR_BURST));
  assign store = (state_q == RD_BURST);

  line_beat_buffer #(
    .beat_width(beat_width)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .load_i    (load),
    .load_dat_i(line_wdata),
    .step_i    (step),
    .store_i   (store),
    .beat_dat_i(burst_rdata),
    .beat_dat_o(burst_wdata),
    .fill_o    (fill_d),
    .last_o    (last_beat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      burst_read_q    <= 1'b0;
      burst_write_q   <= 1'b0;
      line_resp_q     <= 1'b0;
      burst_address_q <= '0;
      line_rdata_q    <= '0;
    end else begin
      line_resp_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (line_write) begin
            state_q         <= WR_BURST;
            burst_write_q   <= 1'b1;
            burst_address_q <= line_address & addr_mask;
`ifdef LINE_ADAPTER_POSTED_WRITE_EN
            line_resp_q     <= 1'b1;
`endif
          end else if (line_read) begin
            state_q         <= RD_BURST;
            burst_read_q    <= 1'b1;
            burst_address_q <= line_address & addr_mask;
          end
        end
        RD_BURST: begin
          // fill_d already contains the beat arriving this cycle
          if (burst_resp && last_beat) begin
            state_q      <= RD_DONE;
            burst_read_q <= 1'b0;
            line_resp_q  <= 1'b1;
            line_rdata_q <= fill_d;
          end
        end
        RD_DONE: state_q <= IDLE;
        WR_BURST: begin
          if (burst_resp && last_beat) begin
            state_q       <= WR_DONE;
            burst_write_q <= 1'b0;
`ifdef LINE_ADAPTER_POSTED_WRITE_EN
            line_resp_q   <= 1'b0;
`else
            line_resp_q   <= 1'b1;
`endif
          end
        end
        WR_DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign burst_read    = burst_read_q;
  assign burst_write   = burst_write_q;
  assign line_resp     = line_resp_q;
  assign burst_address = burst_address_q;
  assign line_rdata    = line_rdata_q;

endmodule

// File: tb/tb_line_burst_adapter.sv
// Scoreboard bench: a cache-side driver queues expected transactions, a memory model serves bursts, a monitor checks responses.
module tb_line_burst_adapter;

`ifdef LINE_ADAPTER_POSTED_WRITE_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         line_read, line_write;
  logic [31:0]  line_address;
  logic [255:0] line_wdata, line_rdata;
  logic         line_resp;
  logic         burst_read, burst_write;
  logic [31:0]  burst_address;
  logic [63:0]  burst_wdata, burst_rdata;
  logic         burst_resp;

  always #5 clk = ~clk;

  line_burst_adapter dut (
    .clk          (clk),
    .rst          (rst),
    .line_read    (line_read),
    .line_write   (line_write),
    .line_address (line_address),
    .line_wdata   (line_wdata),
    .line_rdata   (line_rdata),
    .line_resp    (line_resp),
    .burst_read   (burst_read),
    .burst_write  (burst_write),
    .burst_address(burst_address),
    .burst_wdata  (burst_wdata),
    .burst_rdata  (burst_rdata),
    .burst_resp   (burst_resp)
  );

  typedef struct {
    bit           wr;
    logic [31:0]  addr;
    logic [255:0] line;
  } xact_t;

  xact_t        burst_q[$];
  xact_t        resp_q[$];
  logic [255:0] mem[bit [26:0]];
  logic [255:0] last_rd = '0;
  int           checks = 0;
  int           errors = 0;
  int           gap_mode = 0;
  bit           idle_poke = 1'b0;
  int           resp_cnt = 0;

  // memory-side model state
  int    m_beat = 0;
  int    m_wait = 0;
  bit    m_active = 1'b0;
  xact_t m_cur;
  xact_t mon_e;

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  function automatic logic [255:0] ref_line(input logic [31:0] a);
    logic [255:0] l;
    if (mem.exists(a[31:5])) return mem[a[31:5]];
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = (a & ~32'd31) ^ (32'h9E37_79B9 * (i + 1));
    return l;
  endfunction

  function automatic int next_gap();
    return (gap_mode < 0) ? int'($urandom_range(0, 2)) : gap_mode;
  endfunction

  // Memory model: serves one beat per burst_resp, lowest beat first
  initial begin
    burst_resp  = 1'b0;
    burst_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      burst_resp = 1'b0;
      if (rst) begin
        m_active = 1'b0;
        m_beat   = 0;
      end else if (burst_read || burst_write) begin
        if (!m_active) begin
          m_active = 1'b1;
          m_beat   = 0;
          m_wait   = next_gap();
          chk("burst_excl", burst_read && burst_write, 0);
          if (burst_q.size() == 0) fail_now("unexpected_burst");
          else begin
            m_cur = burst_q.pop_front();
            chk("burst_kind", burst_write, m_cur.wr);
            chk("burst_addr", burst_address, m_cur.addr & ~32'd31);
          end
        end
        if (m_wait == 0) begin
          burst_resp  = 1'b1;
          burst_rdata = m_cur.line[m_beat*64 +: 64];
          if (burst_write) chk($sformatf("wbeat%0d", m_beat), burst_wdata, m_cur.line[m_beat*64 +: 64]);
          m_beat++;
          if (m_beat == 4) m_active = 1'b0;
          else m_wait = next_gap();
        end else begin
          m_wait--;
        end
      end else if (idle_poke) begin
        burst_resp  = 1'b1;
        burst_rdata = '1;
      end
    end
  end

  // Response monitor
  initial begin
    forever begin
      @(negedge clk);
      if (line_resp === 1'b1) begin
        resp_cnt++;
        if (resp_q.size() == 0) fail_now("unexpected_line_resp");
        else begin
          mon_e = resp_q.pop_front();
          if (!mon_e.wr) begin
            chk("line_rdata", line_rdata, mon_e.line);
            last_rd = mon_e.line;
          end else begin
            chk("rdata_hold", line_rdata, last_rd);
          end
        end
      end
    end
  end

  task automatic xact(input bit rd, input bit wr, input logic [31:0] a,
                      input logic [255:0] wd, input int exp_lat);
    xact_t e;
    int    cyc;
    e.wr   = wr;
    e.addr = a;
    e.line = wr ? wd : ref_line(a);
    if (wr) mem[a[31:5]] = wd;
    burst_q.push_back(e);
    resp_q.push_back(e);
    line_read    = rd;
    line_write   = wr;
    line_address = a;
    line_wdata   = wd;
    cyc = 0;
    do begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end while (line_resp !== 1'b1 && cyc < 300);
    if (line_resp !== 1'b1) fail_now($sformatf("timeout addr %h", a));
    else if (exp_lat >= 0) chk($sformatf("latency addr %h", a), cyc, exp_lat);
    @(posedge clk);
    #1;
    line_read  = 1'b0;
    line_write = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((burst_read || burst_write) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) fail_now("wait_idle_timeout");
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [255:0] tp_line;
    logic [255:0] wd;
    xact_t        e;
    int           kind;
    logic [31:0]  a;

    rst = 1'b1; line_read = 1'b0; line_write = 1'b0;
    line_address = '0; line_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_burst_read",  burst_read, 0);
    chk("rst_burst_write", burst_write, 0);
    chk("rst_line_resp",   line_resp, 0);
    chk("rst_burst_addr",  burst_address, 0);
    chk("rst_burst_wdata", burst_wdata, 0);
    chk("rst_line_rdata",  line_rdata, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // back-to-back read of a preloaded line
    gap_mode = 0;
    tp_line = {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}};
    mem[27'(32'h0000_1234 >> 5)] = tp_line;
    xact(1'b1, 1'b0, 32'h0000_1234, '0, 5);
    chk("tp_read_line", line_rdata, tp_line);

    // write with two idle cycles before each beat
    gap_mode = 2;
    xact(1'b0, 1'b1, 32'h8000_0040, {8{32'hDEAD_BEEF}}, POSTED ? 1 : 13);
    wait_idle();

    // simultaneous read and write: write wins
    gap_mode = 0;
    xact(1'b1, 1'b1, 32'h0000_2000, {8{32'h0123_4567}}, POSTED ? 1 : 5);
    wait_idle();

    // write followed immediately by a read of the same line
    xact(1'b0, 1'b1, 32'h0000_3000, {8{32'hA5A5_5A5A}}, POSTED ? 1 : 5);
    xact(1'b1, 1'b0, 32'h0000_3008, '0, POSTED ? 9 : 5);
    wait_idle();

    // burst_resp while idle must be ignored
    kind = resp_cnt;
    idle_poke = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    idle_poke = 1'b0;
    chk("idle_poke_noresp", resp_cnt, kind);
    xact(1'b1, 1'b0, 32'h0000_1234, '0, 5);

    // reset during beat 2 of a read
    e.wr = 1'b0; e.addr = 32'h0000_4000; e.line = ref_line(32'h0000_4000);
    burst_q.push_back(e);
    line_read = 1'b1; line_address = 32'h0000_4000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    line_read = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_burst_read",  burst_read, 0);
    chk("abort_burst_write", burst_write, 0);
    chk("abort_line_resp",   line_resp, 0);
    chk("abort_burst_addr",  burst_address, 0);
    chk("abort_burst_wdata", burst_wdata, 0);
    chk("abort_line_rdata",  line_rdata, 0);
    last_rd = '0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    xact(1'b1, 1'b0, 32'h0000_4010, '0, 5);

    // randomized traffic with random beat gaps
    gap_mode = -1;
    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 2));
      a = 32'h0001_0000 + ($urandom_range(0, 3) << 5) + $urandom_range(0, 31);
      for (int w = 0; w < 8; w++) wd[w*32 +: 32] = $urandom;
      xact(kind != 1, kind != 0, a, wd, -1);
    end
    wait_idle();
    repeat (4) @(posedge clk);
    chk("resp_q_drained",  resp_q.size(), 0);
    chk("burst_q_drained", burst_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/line_burst_adapter.md
# line_burst_adapter

Responder for the cache's 256-bit physical-memory line interface and initiator toward the off-chip burst memory. Each line read or line write from the L2 is converted into a 4-beat × 64-bit burst, with the line gathered or scattered in an internal buffer. Sits between the last-level cache's `pmem_*` ports and the memory model or controller.

## Interface
- `width`, 256, line size in bits; must equal `num_beats` × `beat_width`.
- `beat_width`, 64, burst data-bus width.
- `s_offset`, 5, line-offset bits; the low `s_offset` address bits are zeroed on the burst side.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `line_read`  in  1  line read request; held high until `line_resp`.
- `line_write`  in  1  line write request; held high until `line_resp`.
- `line_address`  in  32  request address.
- `line_wdata`  in  `width`  write line.
- `line_rdata`  out  `width`  read line; valid while `line_resp` is high after a read.
- `line_resp`  out  1  single-cycle completion pulse.
- `burst_read`  out  1  burst read request; held for the whole burst.
- `burst_write`  out  1  burst write request; held for the whole burst.
- `burst_address`  out  32  `{line_address[31:s_offset], '0}`, latched at acceptance.
- `burst_wdata`  out  `beat_width`  current write beat.
- `burst_rdata`  in  `beat_width`  read beat; valid when `burst_resp` is high.
- `burst_resp`  in  1  one beat transferred per high cycle; beats may be non-consecutive.

## Operation
- `num_beats = width/beat_width` is a localparam of 4. The beat counter is `$clog2(num_beats)` bits and wraps to 0 after the last beat.
- States:
  - IDLE
    - `line_write` → latch `line_wdata` and address, go to WR_BURST.
    - else `line_read` → latch address, go to RD_BURST.
    - Write has priority when both requests are high.
  - RD_BURST
    - `burst_read`=1.
    - On each `burst_resp`, store `burst_rdata` at `buf[beat*64 +: 64]` and increment beat.
    - Last beat → RD_DONE.
  - RD_DONE: `line_resp`=1, `line_rdata`=buf, go to IDLE.
  - WR_BURST
    - `burst_write`=1, `burst_wdata`=`buf[beat*64 +: 64]`.
    - On each `burst_resp`, increment beat.
    - Last beat → WR_DONE.
  - WR_DONE: `line_resp` per Configuration, go to IDLE.
- Beat order is always 0..3, lowest address first. There is no critical-word-first ordering.
- `burst_resp` outside RD_BURST/WR_BURST is ignored.
- Requests are sampled only in IDLE. The cache drops its request the cycle after `line_resp`, so IDLE never re-accepts a completed request.
- `line_rdata` holds the last read line until the next read completes.

## Timing
- Reset values:
  - state IDLE, beat 0.
  - `burst_read`, `burst_write`, `line_resp` = 0.
  - `burst_address` = 0, `burst_wdata` = 0, `line_rdata` = 0.
- Reset mid-burst aborts immediately to IDLE with no response. The memory side is reset by the same `rst`.
- Read latency, with request high in cycle 0 and `burst_resp` high in cycles 1–4:
  - `burst_read` is high in cycles 1–4.
  - `line_resp` is high in cycle 5.
  - Each stalled beat adds one cycle.
- Write latency: same burst timing; `line_resp` is high in cycle 5 (without the macro).
- `burst_read`/`burst_write` drop in the cycle after the last beat. They are never high simultaneously.

## Configuration
- `LINE_ADAPTER_POSTED_WRITE_EN`
  - Defined: `line_resp` pulses in the first WR_BURST cycle (cycle 1), since the line is already buffered. WR_DONE produces no pulse. New requests are not accepted until the return to IDLE; the cache stalls on them.
  - Undefined: `line_resp` for writes is issued only in WR_DONE.

## Structure
- `rv32i_types` holds:
  - the state enum `line_adapter_state_t` (IDLE, RD_BURST, RD_DONE, WR_BURST, WR_DONE);
  - the constant `LINE_BEATS = 4`.
- One sub-module, `line_beat_buffer`:
  - owns the `width`-bit buffer and the beat counter;
  - load-full, write-beat, and read-beat ports;
  - last-beat flag.

## Test plan
- Read 0x0000_1234, memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 back-to-back → `burst_address`=0x0000_1220; `line_resp` in cycle 5; `line_rdata`={0x44..44, 0x33..33, 0x22..22, 0x11..11}.
- Write line 0xDEAD…BEEF to 0x8000_0040 with `burst_resp` gaps of 2 cycles between beats → beats presented low-to-high; each is held until its `burst_resp`; `line_resp` one cycle after the 4th beat.
- `line_read` and `line_write` high together in IDLE → write burst performed; no `burst_read` issued.
- `rst` asserted during beat 2 of a read → next cycle IDLE; all outputs 0; a following read completes normally with beat order restarting at 0.
- With `LINE_ADAPTER_POSTED_WRITE_EN`: write then immediate read → write `line_resp` in cycle 1; read accepted only after write burst ends; read `line_resp` 5 cycles after re-entering IDLE.
- `burst_resp` pulsed while IDLE → no state change, no `line_resp`.
